// File: rtl/parallel2serial_stream.sv
// rtl/parallel2serial_stream.sv - WIDTH-bit word to 1-bit stream converter with one-word hold buffer
// Optional even-parity bit per frame when P2S_PARITY_EN is defined.
module parallel2serial_stream #(
   parameter int WIDTH = 2,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk_sig,
   input  logic             reset_sig,
   input  logic [WIDTH-1:0] parallel_sig,
   input  logic             in_valid_sig,
   output logic             in_ready_sig,
   input  logic             lsb_first_sig,
   output logic             serial_sig,
   output logic             serial_valid_sig,
   output logic             frame_start_sig
);

`ifdef P2S_PARITY_EN
   localparam int FRAME_W = WIDTH + 1;
`else
   localparam int FRAME_W = WIDTH;
`endif
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t             state;
   state_t             next_state;
   logic [FRAME_W-1:0] shifter;
   logic [FRAME_W-1:0] hold;
   logic               hold_full;
   logic [CNT_W-1:0]   cnt;

   logic [WIDTH-1:0]   ordered_word;
   logic [FRAME_W-1:0] new_frame;
   logic               accept;
   logic               last_bit;

   // Frames are stored pre-ordered so the shifter always emits from its top bit.
   always_comb begin
      ordered_word = parallel_sig;
      if (lsb_first_sig) begin
         for (int i = 0; i < WIDTH; i++) begin
            ordered_word[i] = parallel_sig[WIDTH-1-i];
         end
      end
`ifdef P2S_PARITY_EN
      new_frame = {ordered_word, ^parallel_sig};
`else
      new_frame = ordered_word;
`endif
   end

   assign accept   = in_valid_sig & in_ready_sig;
   assign last_bit = (state == ST_SHIFT) && (cnt == LAST_CNT);

   always_ff @(posedge clk_sig or negedge reset_sig) begin
      if (!reset_sig) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               next_state = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (last_bit && !hold_full && !accept) begin
               next_state = ST_IDLE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_sig or negedge reset_sig) begin
      if (!reset_sig) begin
         shifter   <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  shifter <= new_frame;
                  cnt     <= '0;
               end
            end
            ST_SHIFT: begin
               if (last_bit) begin
                  // Held word takes priority; in_ready is low whenever hold is full.
                  cnt <= '0;
                  if (hold_full) begin
                     shifter   <= hold;
                     hold_full <= 1'b0;
                  end else if (accept) begin
                     shifter <= new_frame;
                  end else begin
                     shifter <= '0;
                  end
               end else begin
                  shifter <= {shifter[FRAME_W-2:0], 1'b0};
                  cnt     <= cnt + CNT_W'(1);
                  if (accept) begin
                     hold      <= new_frame;
                     hold_full <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      in_ready_sig     = !hold_full;
      serial_valid_sig = (state == ST_SHIFT);
      serial_sig       = serial_valid_sig & shifter[FRAME_W-1];
      frame_start_sig  = serial_valid_sig && (cnt == '0);
   end

endmodule

// File: tb/tb_parallel2serial_stream.sv
// tb/tb_parallel2serial_stream.sv - self-checking bench for parallel2serial_stream (WIDTH=4)
// Expected frames follow P2S_PARITY_EN when it is defined.
module tb_parallel2serial_stream;

   localparam int WIDTH = 4;
`ifdef P2S_PARITY_EN
   localparam int FRAME_W = WIDTH + 1;
`else
   localparam int FRAME_W = WIDTH;
`endif

   logic             clk_sig = 1'b0;
   logic             reset_sig;
   logic [WIDTH-1:0] parallel_sig;
   logic             in_valid_sig;
   logic             in_ready_sig;
   logic             lsb_first_sig;
   logic             serial_sig;
   logic             serial_valid_sig;
   logic             frame_start_sig;

   parallel2serial_stream #(.WIDTH(WIDTH)) dut (
      .clk_sig          (clk_sig),
      .reset_sig        (reset_sig),
      .parallel_sig     (parallel_sig),
      .in_valid_sig     (in_valid_sig),
      .in_ready_sig     (in_ready_sig),
      .lsb_first_sig    (lsb_first_sig),
      .serial_sig       (serial_sig),
      .serial_valid_sig (serial_valid_sig),
      .frame_start_sig  (frame_start_sig)
   );

   always #5 clk_sig = ~clk_sig;

   typedef struct {
      logic b;
      logic first;
   } ebit_t;

   typedef struct {
      logic [WIDTH-1:0] w;
      logic             l;
   } word_t;

   ebit_t q[$];
   word_t src_q[$];
   logic  cap[$];
   int    cap_cyc[$];
   int    fs_cnt = 0;
   int    cyc = 0;
   int    tests = 0;
   int    fails = 0;
   logic  chk_en = 1'b0;

   always @(posedge clk_sig) cyc <= cyc + 1;

   // Model: a queue of bits still owed on the wire; ready while at most one frame is owed.
   always @(posedge clk_sig or negedge reset_sig) begin
      if (!reset_sig) begin
         q.delete();
      end else begin
         logic acc;
         acc = in_valid_sig && (q.size() <= FRAME_W);
         if (q.size() != 0) void'(q.pop_front());
         if (acc) begin
            for (int i = 0; i < WIDTH; i++) begin
               int idx;
               idx = lsb_first_sig ? i : WIDTH - 1 - i;
               q.push_back('{b: parallel_sig[idx], first: (i == 0)});
            end
`ifdef P2S_PARITY_EN
            q.push_back('{b: ^parallel_sig, first: 1'b0});
`endif
            if (src_q.size() != 0) void'(src_q.pop_front());
         end
      end
   end

   always @(negedge clk_sig) begin
      if (chk_en) begin
         logic [3:0] act;
         logic [3:0] exp;
         act = {serial_valid_sig, serial_sig, frame_start_sig, in_ready_sig};
         if (q.size() != 0) exp = {1'b1, q[0].b, q[0].first, (q.size() <= FRAME_W)};
         else               exp = 4'b0001;
         tests++;
         if (act !== exp) begin
            fails++;
            $display("FAIL cycle_check t=%0t {valid,serial,fs,ready} got=%b expected=%b", $time, act, exp);
         end
      end
      if (serial_valid_sig === 1'b1) begin
         cap.push_back(serial_sig);
         cap_cyc.push_back(cyc);
         if (frame_start_sig === 1'b1) fs_cnt++;
      end
   end

   task automatic check_val(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask

   task automatic check_bits(input string name, input logic [31:0] exp, input int n);
      logic [31:0] got;
      got = '0;
      for (int i = 0; i < cap.size() && i < 32; i++) got = {got[30:0], cap[i]};
      tests++;
      if (cap.size() != n || got !== exp) begin
         fails++;
         $display("FAIL %s got=%b (%0d bits) expected=%b (%0d bits)", name, got, cap.size(), exp, n);
      end
   endtask

   task automatic check_contig(input string name);
      int span;
      span = (cap.size() == 0) ? 0 : cap_cyc[cap.size()-1] - cap_cyc[0] + 1;
      check_val(name, span, cap.size());
   endtask

   task automatic clear_cap();
      cap.delete();
      cap_cyc.delete();
      fs_cnt = 0;
   endtask

   task automatic push_word(input logic [WIDTH-1:0] w, input logic l);
      src_q.push_back('{w: w, l: l});
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while ((src_q.size() != 0 || q.size() != 0) && n < budget) begin
         @(negedge clk_sig);
         if (src_q.size() != 0) begin
            in_valid_sig  = 1'b1;
            parallel_sig  = src_q[0].w;
            lsb_first_sig = src_q[0].l;
         end else begin
            in_valid_sig = 1'b0;
         end
         n++;
      end
      in_valid_sig = 1'b0;
      check_val({name, "_timeout"}, (n < budget) ? 1 : 0, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      reset_sig     = 1'b0;
      in_valid_sig  = 1'b0;
      parallel_sig  = '0;
      lsb_first_sig = 1'b0;
      repeat (3) @(negedge clk_sig);
      #1 check_val("reset_outputs", {serial_valid_sig, serial_sig, frame_start_sig, in_ready_sig}, 4'b0001);
      @(negedge clk_sig);
      reset_sig = 1'b1;
      chk_en    = 1'b1;

      clear_cap();
      repeat (10) @(negedge clk_sig);
      check_val("idle_no_bits", cap.size(), 0);
      check_val("idle_ready", in_ready_sig, 1);

      clear_cap();
      push_word(4'b1011, 1'b0);
      drain("single", 50);
`ifdef P2S_PARITY_EN
      check_bits("single_bits", 32'b10111, 5);
`else
      check_bits("single_bits", 32'b1011, 4);
`endif
      check_val("single_fs", fs_cnt, 1);

      clear_cap();
      push_word(4'b1011, 1'b1);
      push_word(4'b0110, 1'b1);
      drain("lsb_pair", 50);
`ifdef P2S_PARITY_EN
      check_bits("lsb_pair_bits", 32'b1101101100, 10);
`else
      check_bits("lsb_pair_bits", 32'b11010110, 8);
`endif
      check_contig("lsb_pair_no_bubble");
      check_val("lsb_pair_fs", fs_cnt, 2);

      clear_cap();
      push_word(4'b1100, 1'b0);
      push_word(4'b1010, 1'b0);
      push_word(4'b0001, 1'b0);
      push_word(4'b1111, 1'b0);
      push_word(4'b0110, 1'b0);
      drain("five", 100);
`ifdef P2S_PARITY_EN
      check_bits("five_bits", 32'b1100010100000111111001100, 25);
`else
      check_bits("five_bits", 32'b11001010000111110110, 20);
`endif
      check_contig("five_no_bubble");
      check_val("five_fs", fs_cnt, 5);

      clear_cap();
      push_word(4'b1011, 1'b0);
      push_word(4'b0110, 1'b0);
      push_word(4'b1111, 1'b0);
      begin
         int n;
         n = 0;
         while (cap.size() < 2 && n < 50) begin
            @(negedge clk_sig);
            if (src_q.size() != 0) begin
               in_valid_sig  = 1'b1;
               parallel_sig  = src_q[0].w;
               lsb_first_sig = src_q[0].l;
            end
            n++;
         end
         check_val("abort_reach_bit2", (n < 50) ? 1 : 0, 1);
      end
      #2 reset_sig = 1'b0;
      in_valid_sig = 1'b0;
      src_q.delete();
      #1 check_val("abort_async_outputs", {serial_valid_sig, serial_sig, frame_start_sig, in_ready_sig}, 4'b0001);
      repeat (2) @(negedge clk_sig);
      #2 reset_sig = 1'b1;
      repeat (3) @(negedge clk_sig);
      clear_cap();
      push_word(4'b1000, 1'b0);
      drain("after_abort", 50);
`ifdef P2S_PARITY_EN
      check_bits("after_abort_bits", 32'b10001, 5);
`else
      check_bits("after_abort_bits", 32'b1000, 4);
`endif

      clear_cap();
      push_word(4'b1011, 1'b0);
      push_word(4'b0011, 1'b0);
      drain("msb_pair", 50);
`ifdef P2S_PARITY_EN
      check_bits("msb_pair_bits", 32'b1011100110, 10);
`else
      check_bits("msb_pair_bits", 32'b10110011, 8);
`endif
      check_contig("msb_pair_no_bubble");

      repeat (3) @(negedge clk_sig);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/parallel2serial_stream.md
Name: parallel2serial_stream

Overview:
- Parametrised successor to the fixed-ratio parallel-to-serial converter.
- Converts WIDTH-bit words into a continuous 1-bit stream at one bit per clk_sig, with a valid/ready handshake on the parallel side.
- Has a one-word holding buffer for gap-free streaming, a per-word MSB/LSB-first selection and a frame-start strobe.
- Sits between the convolutional-encoder word interface and bit-serial channel or modulator blocks.
- No fixed clock-ratio requirement.

Parameters:
- WIDTH, 2, parallel word width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not to be overridden.

Ports:
- clk_sig  input  1  clock; all logic on the rising edge.
- reset_sig  input  1  asynchronous, active-low reset.
- parallel_sig  input  WIDTH  parallel word; bit 0 is the LSB.
- in_valid_sig  input  1  parallel_sig holds a valid word.
- in_ready_sig  output  1  block can accept a word this cycle.
- lsb_first_sig  input  1  bit order for the word being accepted; sampled only on accept (1 = LSB first, 0 = MSB first).
- serial_sig  output  1  serial data bit.
- serial_valid_sig  output  1  serial_sig carries a valid bit this cycle.
- frame_start_sig  output  1  high during the first bit of each word.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - Outputs: serial_sig=0, serial_valid_sig=0, frame_start_sig=0, in_ready_sig=1.
  - Internal: shifter, hold buffer, counter and state all cleared.
- Reset mid-word aborts the word and drops any held word. No partial bits after release.
- Accept: occurs on a clock edge where in_valid_sig & in_ready_sig.
  - in_ready_sig = !hold_full; combinational from the register only.
  - The word is stored already reordered per lsb_first_sig, so the shifter always emits from its top bit.
- State machine IDLE / SHIFT:
  - IDLE: serial_valid_sig=0. On accept, load the shifter and go to SHIFT with bit counter = 0.
  - SHIFT: each edge shifts one bit and increments the counter. The edge where counter = WIDTH-1 is the last-bit edge.
- At the last-bit edge:
  - If hold_full: the hold word moves into the shifter, hold_full clears, counter = 0, stay in SHIFT.
  - Else if accept occurs this edge: the new word goes straight into the shifter, stay in SHIFT.
  - Else: go to IDLE.
- Accept during SHIFT, not at the last-bit edge: the word goes to the hold buffer and hold_full sets.
  - in_ready_sig deasserts the next cycle.
  - in_ready_sig reasserts in the cycle after the hold buffer drains.
- Latency: a word accepted at edge N shows its first bit on serial_sig (serial_valid_sig=1, frame_start_sig=1) in the cycle after edge N.
- Outputs are registered; no combinational path from inputs to outputs.
- Streaming: with in_valid_sig held high, serial_valid_sig stays high continuously with no bubble between words. Throughput is one word per WIDTH cycles.
- frame_start_sig is high exactly when counter = 0 and serial_valid_sig = 1.
- While in_valid_sig=1 and in_ready_sig=0, parallel_sig is ignored. The source must hold it; it is not lost.
- Bits of one word are never reordered or mixed with another word.

Optional Feature:
- Macro: P2S_PARITY_EN.
- Defined: every word is followed by one even-parity bit, the XOR of all WIDTH data bits.
  - The frame is WIDTH+1 bits; the last-bit edge occurs at counter = WIDTH.
  - serial_valid_sig stays high during the parity bit; frame_start_sig does not assert on it.
  - Throughput becomes one word per WIDTH+1 cycles.
- Undefined: frames are exactly WIDTH bits and no parity logic is synthesised.

Test Plan:
- WIDTH=4, reset low, then high; no in_valid_sig -> in_ready_sig=1; serial_valid_sig, serial_sig and frame_start_sig stay 0 for 10 cycles.
- WIDTH=4, one word 4'b1011 with lsb_first_sig=0 -> next cycle onward serial_sig = 1,0,1,1; frame_start_sig high on the first bit only; then IDLE.
- WIDTH=4, words 4'b1011 then 4'b0110, both lsb_first_sig=1, in_valid_sig held high -> serial_sig = 1,1,0,1,0,1,1,0 over 8 consecutive cycles; serial_valid_sig never drops; frame_start_sig at bits 0 and 4.
- WIDTH=4, in_valid_sig held high continuously -> in_ready_sig drops the cycle after the hold buffer fills and rises after each drain; no word dropped or duplicated across 5 words.
- WIDTH=4, reset_sig pulsed low asynchronously mid-word (after 2 bits, hold full) -> outputs go to 0 immediately; after release the next accepted word 4'b1000 (MSB first) emits 1,0,0,0 with no leftover bits.
- P2S_PARITY_EN defined, WIDTH=4, words 4'b1011 then 4'b0011, lsb_first_sig=0 -> serial_sig = 1,0,1,1,1,0,0,1,1,0; serial_valid_sig continuous for 10 cycles.
